// File: rtl/store_trace_display.sv
// Store trace display: queues MEM-stage stores in a small FIFO and shows each one on two 4-digit hex groups.
// Optional sticky overflow indicator on the left-group decimal points: define STORE_TRACE_OVF_EN.
module store_trace_display #(
    parameter int DEPTH       = 4,
    parameter int SCAN_DIV    = 50000,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [7:0]  seg,
    output logic [7:0]  seg1,
    output logic [7:0]  an,
    output logic        fifo_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        hex7 = 8'h00;
        case (n)
            4'h0: hex7 = 8'h3F;  4'h1: hex7 = 8'h06;  4'h2: hex7 = 8'h5B;  4'h3: hex7 = 8'h4F;
            4'h4: hex7 = 8'h66;  4'h5: hex7 = 8'h6D;  4'h6: hex7 = 8'h7D;  4'h7: hex7 = 8'h07;
            4'h8: hex7 = 8'h7F;  4'h9: hex7 = 8'h6F;  4'hA: hex7 = 8'h77;  4'hB: hex7 = 8'h7C;
            4'hC: hex7 = 8'h39;  4'hD: hex7 = 8'h5E;  4'hE: hex7 = 8'h79;  4'hF: hex7 = 8'h71;
            default: hex7 = 8'h00;
        endcase
    endfunction

    logic              mw_q;
    logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [31:0]       mem_q [DEPTH];
    state_t            state_q, state_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [31:0]       disp_q, disp_d;
    logic              disp_vld_q, disp_vld_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [1:0]        k_q, k_d;
    logic [7:0]        seg_q, seg_d, seg1_q, seg1_d, an_q, an_d;
    logic              empty, full_w, push_req, push_ok, pop;
    logic              unused_hi;
`ifdef STORE_TRACE_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    assign unused_hi = ^{dataadr[31:16], writedata[31:16]};

    // Pointer comparison: wrap bit distinguishes full from empty
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full_w   = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
    assign push_req = memwrite && !mw_q;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        disp_d     = disp_q;
        disp_vld_d = disp_vld_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    disp_d     = mem_q[rd_ptr_q[PW-1:0]];
                    disp_vld_d = 1'b1;
                    hold_cnt_d = HOLD_LAST;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end else if (!empty) begin
                    pop        = 1'b1;
                    disp_d     = mem_q[rd_ptr_q[PW-1:0]];
                    hold_cnt_d = HOLD_LAST;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees the slot for a push into a full FIFO
        push_ok  = push_req && (!full_w || pop);
        wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        k_d        = k_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            k_d        = k_q + 2'd1;
        end
        an_d   = 8'h11 << k_q;
        seg_d  = disp_vld_q ? hex7(disp_q[{1'b0, k_q, 2'b00} +: 4]) : 8'h40;
        seg1_d = disp_vld_q ? hex7(disp_q[{1'b1, k_q, 2'b00} +: 4]) : 8'h40;
`ifdef STORE_TRACE_OVF_EN
        ovf_d     = ovf_q || (push_req && !push_ok);
        seg1_d[7] = ovf_q;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mw_q       <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            disp_q     <= '0;
            disp_vld_q <= 1'b0;
            scan_cnt_q <= '0;
            k_q        <= 2'd0;
            seg_q      <= 8'h40;
            seg1_q     <= 8'h40;
            an_q       <= 8'h11;
`ifdef STORE_TRACE_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            mw_q       <= memwrite;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            disp_q     <= disp_d;
            disp_vld_q <= disp_vld_d;
            scan_cnt_q <= scan_cnt_d;
            k_q        <= k_d;
            seg_q      <= seg_d;
            seg1_q     <= seg1_d;
            an_q       <= an_d;
`ifdef STORE_TRACE_OVF_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

    // Entry storage carries no reset; the pointers alone define what is pending
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PW-1:0]] <= {dataadr[15:0], writedata[15:0]};
        end
    end

    assign seg       = seg_q;
    assign seg1      = seg1_q;
    assign an        = an_q;
    assign fifo_full = full_w;

endmodule

// File: tb/tb_store_trace_display.sv
// Directed bench for store_trace_display with DEPTH=4, SCAN_DIV=4, HOLD_CYCLES=20.
module tb_store_trace_display;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic [7:0]  seg, seg1, an;
    logic        fifo_full;

    store_trace_display #(.DEPTH(4), .SCAN_DIV(4), .HOLD_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .seg(seg), .seg1(seg1), .an(an), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    int   last_push = 0;
    logic ovf_exp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] font(input logic [3:0] n);
        font = 8'h00;
        case (n)
            4'h0: font = 8'h3F;  4'h1: font = 8'h06;  4'h2: font = 8'h5B;  4'h3: font = 8'h4F;
            4'h4: font = 8'h66;  4'h5: font = 8'h6D;  4'h6: font = 8'h7D;  4'h7: font = 8'h07;
            4'h8: font = 8'h7F;  4'h9: font = 8'h6F;  4'hA: font = 8'h77;  4'hB: font = 8'h7C;
            4'hC: font = 8'h39;  4'hD: font = 8'h5E;  4'hE: font = 8'h79;  4'hF: font = 8'h71;
            default: font = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] left(input logic [3:0] n);
        left = font(n) | {ovf_exp, 7'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        @(negedge clk);
        last_push = cyc;
        memwrite  = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_digit(input string tag, input logic [7:0] an_e,
                             input logic [7:0] seg1_e, input logic [7:0] seg_e);
        int i;
        i = 0;
        while (an !== an_e && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_an"}, {24'h0, an}, {24'h0, an_e});
        chk({tag, "_seg1"}, {24'h0, seg1}, {24'h0, seg1_e});
        chk({tag, "_seg"}, {24'h0, seg}, {24'h0, seg_e});
    endtask

    initial begin
        int r, p, pa, pb, pe, bad;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", {24'h0, seg}, 32'h40);
        chk("rst_seg1", {24'h0, seg1}, 32'h40);
        chk("rst_an", {24'h0, an}, 32'h11);
        chk("rst_full", {31'h0, fifo_full}, 32'h0);
        rst = 1'b1;
        r = cyc;

        // Idle scan
        wait_until(r + 4);  chk("scan_an0", {24'h0, an}, 32'h11);
        wait_until(r + 5);  chk("scan_an1", {24'h0, an}, 32'h22);
        wait_until(r + 8);  chk("scan_an1b", {24'h0, an}, 32'h22);
        wait_until(r + 9);  chk("scan_an2", {24'h0, an}, 32'h44);
        wait_until(r + 13); chk("scan_an3", {24'h0, an}, 32'h88);
        wait_until(r + 17); chk("scan_an4", {24'h0, an}, 32'h11);
        wait_until(r + 40);
        chk("idle_seg", {24'h0, seg}, 32'h40);
        chk("idle_seg1", {24'h0, seg1}, 32'h40);
        chk("idle_full", {31'h0, fifo_full}, 32'h0);

        // Long memwrite level gives a single push
        memwrite  = 1'b1;
        dataadr   = 32'h0000_0054;
        writedata = 32'h0000_0007;
        p = cyc + 1;
        repeat (30) @(negedge clk);
        memwrite = 1'b0;
        chk("level_full", {31'h0, fifo_full}, 32'h0);
        chk_digit("st54_k0", 8'h11, 8'h66, 8'h07);
        chk_digit("st54_k1", 8'h22, 8'h6D, 8'h3F);
        chk_digit("st54_k2", 8'h44, 8'h3F, 8'h3F);
        chk_digit("st54_k3", 8'h88, 8'h3F, 8'h3F);
        wait_until(p + 60);

        // Burst overflow while an earlier entry holds
        store(32'h0000_0ABC, 32'h0000_0DEF);
        pa = last_push;
        for (int i = 0; i < 6; i++) begin
            store(32'h10 + i, 32'h44 + i);
            if (i == 3) chk("burst_full", {31'h0, fifo_full}, 32'h1);
        end
`ifdef STORE_TRACE_OVF_EN
        ovf_exp = 1'b1;
`endif
        wait_until(pa + 20); chk("full_before_pop", {31'h0, fifo_full}, 32'h1);
        wait_until(pa + 21); chk("full_after_pop", {31'h0, fifo_full}, 32'h0);
        wait_until(pa + 22); chk_digit("walk10", 8'h11, left(4'h0), font(4'h4));
        chk("ovf_dp", {31'h0, seg1[7]}, {31'h0, ovf_exp});
        wait_until(pa + 42); chk_digit("walk11", 8'h11, left(4'h1), font(4'h5));
        wait_until(pa + 62); chk_digit("walk12", 8'h11, left(4'h2), font(4'h6));
        wait_until(pa + 82); chk_digit("walk13", 8'h11, left(4'h3), font(4'h7));
        wait_until(pa + 130); chk_digit("stay13", 8'h11, left(4'h3), font(4'h7));
        chk("stay_full", {31'h0, fifo_full}, 32'h0);

        // Push into full FIFO on the hold-expiry pop cycle
        store(32'h0000_0777, 32'h0000_0888);
        pb = last_push;
        for (int i = 0; i < 4; i++) store(32'h20 + i, 32'h48 + i);
        chk("fill_full", {31'h0, fifo_full}, 32'h1);
        wait_until(pb + 20);
        store(32'h0000_0039, 32'h0000_00E5);
        chk("pushpop_push_edge", last_push, pb + 21);
        chk("pushpop_full", {31'h0, fifo_full}, 32'h1);
        chk_digit("c0", 8'h11, left(4'h0), font(4'h8));
        wait_until(pb + 82);  chk_digit("c3", 8'h11, left(4'h3), font(4'hB));
        wait_until(pb + 102); chk_digit("d_entry", 8'h11, left(4'h9), font(4'h5));
        chk("d_full", {31'h0, fifo_full}, 32'h0);

        // Reset mid-hold with three pending entries
        store(32'h0000_0011, 32'h0000_0022);
        pe = last_push;
        for (int i = 0; i < 3; i++) store(32'h30 + i, 32'h50 + i);
        wait_until(pe + 7);
        rst = 1'b0;
        ovf_exp = 1'b0;
        @(negedge clk);
        chk("mid_rst_seg", {24'h0, seg}, 32'h40);
        chk("mid_rst_seg1", {24'h0, seg1}, 32'h40);
        chk("mid_rst_an", {24'h0, an}, 32'h11);
        chk("mid_rst_full", {31'h0, fifo_full}, 32'h0);
        rst = 1'b1;
        bad = 0;
        repeat (120) begin
            @(negedge clk);
            if (seg !== 8'h40 || seg1 !== 8'h40) bad++;
        end
        chk("no_replay", bad, 0);

        // Fresh store after reset; overflow indication cleared
        store(32'h0000_000A, 32'h0000_000B);
        chk_digit("post_rst", 8'h11, 8'h77, 8'h7C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
